div_sequencer: RTL
==================

// Module: div_sequencer
// PURPOSE
//  Sequences the multicycle div datapath for EX-stage DIV/DIVU instructions.
//  Latches the operands and holds them stable, and drives the divider start/annul protocol.
//  Stalls the pipeline while the divide runs and writes the 64-bit result to HI/LO.
//  Sits between the EX stage, the hazard unit and the hilo register.
// PARAMETERS
//  ABORT_CYC   3   cycles start=0/annul=1 are held after a flush (divider back to free)
//  TIMEOUT_CYC 40  BUSY cycles without div_ready before div_err is raised (>=34)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low
//  alucontrolE  in   5   EX alu op; request = DIV_CONTROL or DIVU_CONTROL (defines2.vh)
//  srcaE        in   32  dividend of EX instruction
//  srcbE        in   32  divisor of EX instruction
//  flushE       in   1   EX flush (exception/branch); kills the in-flight divide
//  div_ready    in   1   divider result valid (held until start drops)
//  div_result   in   64  divider result {remainder, quotient}
//  div_start    out  1   divider start; high = run, low = stop
//  div_annul    out  1   divider annul
//  div_ctrl     out  5   latched alucontrol to divider (stable while BUSY)
//  div_op1      out  32  latched dividend
//  div_op2      out  32  latched divisor
//  stall_div    out  1   stall request to hazard unit
//  hilo_we      out  1   one-cycle hilo write enable
//  hilo_wdata   out  64  {hi=remainder, lo=quotient}
//  div_err      out  1   sticky: divider exceeded TIMEOUT_CYC; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; op/ctrl/result registers 0; counters 0.
//  req = (alucontrolE==DIV_CONTROL || alucontrolE==DIVU_CONTROL) && !flushE.
//  IDLE : req -> latch srcaE/srcbE/alucontrolE, go BUSY. stall_div=req (comb), start=0.
//  BUSY : start=1, stall_div=1, op/ctrl registers frozen, cycle counter counts.
//    flushE           -> ABORT (start=0, annul=1 from next cycle). Flush has priority over ready.
//    div_ready        -> capture div_result into result register, go DONE.
//    count==TIMEOUT_CYC -> set div_err, go ABORT.
//  DONE : start=0 (divider leaves end state), stall_div=0, hilo_we=!flushE.
//         hilo_wdata=result register. The div instruction leaves EX at the end of this cycle.
//         req ignored; always -> IDLE.
//  ABORT: start=0, annul=1, stall_div=0. Down-counter from ABORT_CYC.
//         Returns to IDLE at 0; req during ABORT is stalled (stall_div=req).
//  Latency: req in IDLE at cycle 0, divider ready at cycle N.
//    hilo_we at N+1; non-zero divide is 35 cycles from req to hilo_we.
//  Back-to-back DIVs: second starts from IDLE no earlier than 2 cycles after DONE.
//    This guarantees one start-low cycle between divides.
//  hilo_wdata is a don't-care (holds last result) when hilo_we=0.
//  Reset mid-operation: returns to IDLE at once; divider is reset by the same rst.
// CONFIGURATION
//  DIV_ZERO_BYPASS_EN defined: IDLE with req and srcbE==0 skips the divider.
//    The result register is loaded with 64'h0 and the next state is DONE.
//    hilo_we occurs 1 cycle after req; div_start never asserts.
//  Not defined: a zero divisor goes through the divider like any other operand.
//    The divider returns 64'h0 via its by-zero path, about 3 cycles.
// TESTING
//  DIV 100/7 -> stall 34+ cycles, one hilo_we, hilo_wdata=64'h00000002_0000000E.
//  DIV -100/7 -> hilo_wdata=64'hFFFFFFFE_FFFFFFF2.
//  DIVU 32'hFFFFFFFF/2 -> 64'h00000001_7FFFFFFF.
//  flushE 10 cycles into BUSY -> ABORT: annul high ABORT_CYC cycles, no hilo_we.
//    A following DIV still returns correct results.
//  Two DIVs back-to-back -> two hilo_we pulses, correct results.
//    At least one start-low cycle between the two divides.
//  Divisor 0 -> hilo_wdata=0; with DIV_ZERO_BYPASS_EN hilo_we 1 cycle after req.
//    Also with DIV_ZERO_BYPASS_EN, div_start stays 0.
//  div_ready tied low -> div_err after TIMEOUT_CYC, pipeline released.
//    rst clears div_err.

Source files
------------

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: handshake and operand bus between the divide sequencer
// and the multicycle divider datapath.
interface div_sequencer_if;
   logic        div_start;
   logic        div_annul;
   logic [4:0]  div_ctrl;
   logic [31:0] div_op1;
   logic [31:0] div_op2;
   logic        div_ready;
   logic [63:0] div_result;

   modport master (
      output div_start,
      output div_annul,
      output div_ctrl,
      output div_op1,
      output div_op2,
      input  div_ready,
      input  div_result
   );

   modport slave (
      input  div_start,
      input  div_annul,
      input  div_ctrl,
      input  div_op1,
      input  div_op2,
      output div_ready,
      output div_result
   );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: sequences the multicycle divider for EX-stage DIV/DIVU.
// Latches the operands, runs the start/annul protocol, stalls the pipeline
// while the divide runs and hands the {remainder, quotient} pair to HI/LO.
// Optional build macro: DIV_ZERO_BYPASS_EN -- a zero divisor skips the
// divider and produces a zero result one cycle after the request.
module div_sequencer #(
   parameter int         ABORT_CYC    = 3,
   parameter int         TIMEOUT_CYC  = 40,
   parameter logic [4:0] DIV_CONTROL  = 5'b11010,
   parameter logic [4:0] DIVU_CONTROL = 5'b11011
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      alucontrolE,
   input  logic [31:0]     srcaE,
   input  logic [31:0]     srcbE,
   input  logic            flushE,
   div_sequencer_if.master div_bus,
   output logic            stall_div,
   output logic            hilo_we,
   output logic [63:0]     hilo_wdata,
   output logic            div_err
);

   // The busy counter must reach TIMEOUT_CYC; the abort counter starts at
   // ABORT_CYC-1 and runs down to zero, giving ABORT_CYC annul cycles.
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam int ABT_W = (ABORT_CYC > 1) ? $clog2(ABORT_CYC) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
   localparam logic [ABT_W-1:0] ABORT_LOAD  = ABT_W'(ABORT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      ABORT = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       op1_q, op1_d;
   logic [31:0]       op2_q, op2_d;
   logic [4:0]        ctrl_q, ctrl_d;
   logic [63:0]       result_q, result_d;
   logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
   logic [ABT_W-1:0]  abort_cnt_q, abort_cnt_d;
   logic              err_q, err_d;

   logic              req;
   logic              start_c;
   logic              annul_c;
   logic              stall_c;
   logic              we_c;

   // A divide request is a DIV/DIVU op in EX that is not being flushed.
   assign req = ((alucontrolE == DIV_CONTROL) || (alucontrolE == DIVU_CONTROL)) && !flushE;

   // State and datapath registers; reset puts everything back to IDLE/zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         op1_q       <= '0;
         op2_q       <= '0;
         ctrl_q      <= '0;
         result_q    <= '0;
         busy_cnt_q  <= '0;
         abort_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         ctrl_q      <= ctrl_d;
         result_q    <= result_d;
         busy_cnt_q  <= busy_cnt_d;
         abort_cnt_q <= abort_cnt_d;
         err_q       <= err_d;
      end
   end

   // Next-state and output decode; in BUSY a flush beats a ready result,
   // and a ready result beats the timeout.
   always_comb begin
      state_d     = state_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      ctrl_d      = ctrl_q;
      result_d    = result_q;
      busy_cnt_d  = busy_cnt_q;
      abort_cnt_d = abort_cnt_q;
      err_d       = err_q;
      start_c     = 1'b0;
      annul_c     = 1'b0;
      stall_c     = 1'b0;
      we_c        = 1'b0;

      case (state_q)
         IDLE: begin
            stall_c = req;
            if (req) begin
               op1_d      = srcaE;
               op2_d      = srcbE;
               ctrl_d     = alucontrolE;
               busy_cnt_d = '0;
`ifdef DIV_ZERO_BYPASS_EN
               if (srcbE == 32'h0) begin
                  result_d = 64'h0;
                  state_d  = DONE;
               end else begin
                  state_d  = BUSY;
               end
`else
               state_d    = BUSY;
`endif
            end
         end

         BUSY: begin
            start_c    = 1'b1;
            stall_c    = 1'b1;
            busy_cnt_d = busy_cnt_q + CNT_W'(1);
            if (flushE) begin
               abort_cnt_d = ABORT_LOAD;
               state_d     = ABORT;
            end else if (div_bus.div_ready) begin
               result_d    = div_bus.div_result;
               state_d     = DONE;
            end else if (busy_cnt_q == TIMEOUT_VAL) begin
               err_d       = 1'b1;
               abort_cnt_d = ABORT_LOAD;
               state_d     = ABORT;
            end
         end

         DONE: begin
            we_c    = !flushE;
            state_d = IDLE;
         end

         ABORT: begin
            annul_c = 1'b1;
            stall_c = req;
            if (abort_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               abort_cnt_d = abort_cnt_q - ABT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign div_bus.div_start = start_c;
   assign div_bus.div_annul = annul_c;
   assign div_bus.div_ctrl  = ctrl_q;
   assign div_bus.div_op1   = op1_q;
   assign div_bus.div_op2   = op2_q;

   assign stall_div  = stall_c;
   assign hilo_we    = we_c;
   assign hilo_wdata = result_q;
   assign div_err    = err_q;

endmodule
